// File: rtl/alu_cmp_seq_pkg.sv
// Shared definitions for the byte-serial compare sequencer: FSM state
// encodings, the default operand width and the byte-index width helper.
package alu_cmp_seq_pkg;

   // Default operand width in bytes.
   localparam int NBYTES_DEF = 4;

   // Sequencer states; encodings are fixed so external observers can decode them.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMP  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Width of a byte index that must hold every value 1..nbytes.
   function automatic int idx_bits(input int nbytes);
      if (nbytes < 1) begin
         return 1;
      end else begin
         return $clog2(nbytes + 1);
      end
   endfunction

endpackage

// File: rtl/alu_cmp_byte_mux.sv
// Selects byte[idx] (byte k = bits 8k:8k-7) from each operand. An index
// outside 1..NBYTES yields zero bytes so the comparator bus stays quiet.
module alu_cmp_byte_mux
   import alu_cmp_seq_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEF
) (
   input  logic [8*NBYTES:1]          a_i,
   input  logic [8*NBYTES:1]          b_i,
   input  logic [idx_bits(NBYTES)-1:0] idx_i,
   output logic [7:0]                 a_byte_o,
   output logic [7:0]                 b_byte_o
);

   localparam int IDX_W = idx_bits(NBYTES);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NBYTES);

   logic [7:0] a_bytes_s [1:NBYTES];
   logic [7:0] b_bytes_s [1:NBYTES];

   for (genvar k = 1; k <= NBYTES; k++) begin : g_bytes
      assign a_bytes_s[k] = a_i[8*k -: 8];
      assign b_bytes_s[k] = b_i[8*k -: 8];
   end

   // Pick the indexed byte pair, or zeros for an out-of-range index.
   always_comb begin
      a_byte_o = 8'h00;
      b_byte_o = 8'h00;
      if ((idx_i >= IDX_ONE) && (idx_i <= IDX_MAX)) begin
         a_byte_o = a_bytes_s[idx_i];
         b_byte_o = b_bytes_s[idx_i];
      end else begin
         a_byte_o = 8'h00;
         b_byte_o = 8'h00;
      end
   end

endmodule

// File: rtl/alu_cmp_seq.sv
// Byte-serial equality compare of two NBYTES-wide operands through an
// external 8-bit comparator, most-significant byte first, stopping at the
// first mismatching byte. All outputs come straight from registers.
module alu_cmp_seq
   import alu_cmp_seq_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [8*NBYTES:1] a_word,
   input  logic [8*NBYTES:1] b_word,
   output logic              busy,
   output logic              done,
   output logic              eq_flag,
   output logic [8:1]        cmp_a,
   output logic [8:1]        cmp_b,
   output logic              cmp_en,
   input  logic              cmp_eq
);

   localparam int IDX_W = idx_bits(NBYTES);
   localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NBYTES);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [8*NBYTES:1]   a_q, a_d;
   logic [8*NBYTES:1]   b_q, b_d;
   logic                eq_q, eq_d;
   logic                busy_q;
   logic                done_q;
   logic                cmp_en_q;
   logic [7:0]          cmp_a_q;
   logic [7:0]          cmp_b_q;
   logic [7:0]          sel_a_s;
   logic [7:0]          sel_b_s;

   // The mux looks at next-state operands and index so the comparator
   // bytes can be registered and valid for the whole CMP cycle.
   alu_cmp_byte_mux #(
      .NBYTES (NBYTES)
   ) u_byte_mux (
      .a_i      (a_d),
      .b_i      (b_d),
      .idx_i    (idx_d),
      .a_byte_o (sel_a_s),
      .b_byte_o (sel_b_s)
   );

   // Next-state logic; cmp_eq is only consulted in CMP, where cmp_en is high.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      eq_d    = eq_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_CMP;
               a_d     = a_word;
               b_d     = b_word;
               idx_d   = IDX_MAX;
               eq_d    = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_CMP: begin
            if (!cmp_eq) begin
               state_d = ST_DONE;
               eq_d    = 1'b0;
            end else if (idx_q > IDX_ONE) begin
               idx_d   = idx_q - IDX_ONE;
            end else begin
               state_d = ST_DONE;
               eq_d    = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, operand latches and registered outputs; rst abandons any compare.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         idx_q    <= IDX_MAX;
         a_q      <= '0;
         b_q      <= '0;
         eq_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         cmp_en_q <= 1'b0;
         cmp_a_q  <= 8'h00;
         cmp_b_q  <= 8'h00;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         eq_q     <= eq_d;
         busy_q   <= (state_d != ST_IDLE);
         done_q   <= (state_d == ST_DONE);
         cmp_en_q <= (state_d == ST_CMP);
         cmp_a_q  <= (state_d == ST_CMP) ? sel_a_s : 8'h00;
         cmp_b_q  <= (state_d == ST_CMP) ? sel_b_s : 8'h00;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign eq_flag = eq_q;
   assign cmp_en  = cmp_en_q;
   assign cmp_a   = cmp_a_q;
   assign cmp_b   = cmp_b_q;

endmodule

// File: tb/tb_alu_cmp_seq.sv
// Directed bench for alu_cmp_seq: a 4-byte instance and a 1-byte instance,
// each wired to a behavioural 8-bit comparator. Cycle n is the clock period
// following the n-th rising edge, the start edge being edge 0.
module tb_alu_cmp_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start = 1'b0;
   logic [32:1] a_word = 32'h0;
   logic [32:1] b_word = 32'h0;
   logic        busy, done, eq_flag, cmp_en, cmp_eq;
   logic [8:1]  cmp_a, cmp_b;

   logic        start1 = 1'b0;
   logic [8:1]  a_word1 = 8'h00;
   logic [8:1]  b_word1 = 8'h00;
   logic        busy1, done1, eq_flag1, cmp_en1, cmp_eq1;
   logic [8:1]  cmp_a1, cmp_b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Comparator models: equality while enabled, idle-low bus otherwise.
   assign cmp_eq  = cmp_en  ? (cmp_a  == cmp_b)  : 1'b0;
   assign cmp_eq1 = cmp_en1 ? (cmp_a1 == cmp_b1) : 1'b0;

   alu_cmp_seq #(.NBYTES(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .a_word(a_word), .b_word(b_word),
      .busy(busy), .done(done), .eq_flag(eq_flag), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .cmp_en(cmp_en), .cmp_eq(cmp_eq)
   );

   alu_cmp_seq #(.NBYTES(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .a_word(a_word1), .b_word(b_word1),
      .busy(busy1), .done(done1), .eq_flag(eq_flag1), .cmp_a(cmp_a1), .cmp_b(cmp_b1),
      .cmp_en(cmp_en1), .cmp_eq(cmp_eq1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge; returns in cycle 1.
   task automatic start_cmp(input logic [32:1] a, input logic [32:1] b);
      a_word = a;
      b_word = b;
      start  = 1'b1;
      tick();
      start  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy, done, eq_flag, cmp_en, cmp_a, cmp_b} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs got busy=%b done=%b eq=%b en=%b a=%h b=%h exp all 0",
                  busy, done, eq_flag, cmp_en, cmp_a, cmp_b);
      end
      checks++;
      if ({busy1, done1, eq_flag1, cmp_en1, cmp_a1, cmp_b1} !== 20'h0) begin
         errors++;
         $display("FAIL reset_outputs_n1 got busy=%b done=%b eq=%b en=%b a=%h b=%h exp all 0",
                  busy1, done1, eq_flag1, cmp_en1, cmp_a1, cmp_b1);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({busy, done, cmp_en} !== 3'b000) begin
         errors++;
         $display("FAIL reset_release_idle got busy=%b done=%b en=%b exp 000", busy, done, cmp_en);
      end
   endtask

   task automatic test_equal();
      logic [7:0] ea [4];
      ea = '{8'h12, 8'h34, 8'h56, 8'h78};
      start_cmp(32'h12345678, 32'h12345678);
      for (int c = 1; c <= 4; c++) begin
         if (c == 2) begin
            a_word = 32'h00000000;
            b_word = 32'hFFFFFFFF;
         end
         checks++;
         if ({cmp_en, busy, done} !== 3'b110) begin
            errors++;
            $display("FAIL equal_ctrl c%0d got en=%b busy=%b done=%b exp en=1 busy=1 done=0",
                     c, cmp_en, busy, done);
         end
         checks++;
         if (cmp_a !== ea[c-1] || cmp_b !== ea[c-1]) begin
            errors++;
            $display("FAIL equal_bytes c%0d got a=%h b=%h exp %h", c, cmp_a, cmp_b, ea[c-1]);
         end
         tick();
      end
      checks++;
      if ({done, eq_flag, cmp_en, busy} !== 4'b1101 || cmp_a !== 8'h00) begin
         errors++;
         $display("FAIL equal_done c5 got done=%b eq=%b en=%b busy=%b a=%h exp done=1 eq=1 en=0 busy=1 a=00",
                  done, eq_flag, cmp_en, busy, cmp_a);
      end
      tick();
      checks++;
      if ({done, busy, eq_flag} !== 3'b001) begin
         errors++;
         $display("FAIL equal_idle c6 got done=%b busy=%b eq=%b exp 0 0 1", done, busy, eq_flag);
      end
      tick();
      tick();
      checks++;
      if (eq_flag !== 1'b1) begin
         errors++;
         $display("FAIL equal_hold got eq=%b exp 1", eq_flag);
      end
   endtask

   task automatic test_early_mismatch();
      start_cmp(32'hFF345678, 32'h12345678);
      checks++;
      if ({cmp_en, done, eq_flag} !== 3'b100 || cmp_a !== 8'hFF || cmp_b !== 8'h12) begin
         errors++;
         $display("FAIL early_c1 got en=%b done=%b eq=%b a=%h b=%h exp en=1 done=0 eq=0 a=ff b=12",
                  cmp_en, done, eq_flag, cmp_a, cmp_b);
      end
      tick();
      checks++;
      if ({done, eq_flag, cmp_en} !== 3'b100) begin
         errors++;
         $display("FAIL early_done c2 got done=%b eq=%b en=%b exp 1 0 0", done, eq_flag, cmp_en);
      end
      tick();
      checks++;
      if ({done, busy} !== 2'b00) begin
         errors++;
         $display("FAIL early_idle c3 got done=%b busy=%b exp 0 0", done, busy);
      end
   endtask

   task automatic test_last_byte();
      logic [7:0] ea [4];
      logic [7:0] eb [4];
      ea = '{8'h12, 8'h34, 8'h56, 8'h00};
      eb = '{8'h12, 8'h34, 8'h56, 8'h01};
      start_cmp(32'h12345600, 32'h12345601);
      for (int c = 1; c <= 4; c++) begin
         checks++;
         if (cmp_a !== ea[c-1] || cmp_b !== eb[c-1] || done !== 1'b0 || cmp_en !== 1'b1) begin
            errors++;
            $display("FAIL last_seq c%0d got a=%h b=%h done=%b en=%b exp a=%h b=%h done=0 en=1",
                     c, cmp_a, cmp_b, done, cmp_en, ea[c-1], eb[c-1]);
         end
         tick();
      end
      checks++;
      if ({done, eq_flag} !== 2'b10) begin
         errors++;
         $display("FAIL last_done c5 got done=%b eq=%b exp 1 0", done, eq_flag);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int n_done = 0;
      int done_cyc = -1;
      start_cmp(32'h12345678, 32'h12345678);
      for (int c = 1; c <= 8; c++) begin
         if (c == 2 || c == 5) begin
            start  = 1'b1;
            a_word = 32'hDEADBEEF;
            b_word = 32'h12345678;
         end else begin
            start = 1'b0;
         end
         if (done === 1'b1) begin
            n_done++;
            done_cyc = c;
         end
         if (c == 6 || c == 7) begin
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL b2b_busy c%0d got busy=%b exp 0", c, busy);
            end
         end
         tick();
      end
      start = 1'b0;
      checks++;
      if (n_done != 1 || done_cyc != 5) begin
         errors++;
         $display("FAIL b2b_done got count=%0d cycle=%0d exp count=1 cycle=5", n_done, done_cyc);
      end
      checks++;
      if (eq_flag !== 1'b1) begin
         errors++;
         $display("FAIL b2b_eq got eq=%b exp 1", eq_flag);
      end
   endtask

   task automatic test_async_reset();
      int n_done = 0;
      int done_cyc = -1;
      start_cmp(32'h12345678, 32'h12345678);
      tick();
      #3;
      rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, eq_flag, cmp_en, cmp_a, cmp_b} !== 20'h0) begin
         errors++;
         $display("FAIL async_rst got busy=%b done=%b eq=%b en=%b a=%h b=%h exp all 0",
                  busy, done, eq_flag, cmp_en, cmp_a, cmp_b);
      end
      tick();
      #2;
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         tick();
         if (done === 1'b1) n_done++;
      end
      checks++;
      if (n_done != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL async_nodone got dones=%0d busy=%b exp 0 0", n_done, busy);
      end
      n_done = 0;
      start_cmp(32'h12345678, 32'h12345678);
      for (int c = 1; c <= 7; c++) begin
         if (done === 1'b1) begin
            n_done++;
            done_cyc = c;
         end
         tick();
      end
      checks++;
      if (n_done != 1 || done_cyc != 5 || eq_flag !== 1'b1) begin
         errors++;
         $display("FAIL async_restart got count=%0d cycle=%0d eq=%b exp 1 5 1", n_done, done_cyc, eq_flag);
      end
   endtask

   task automatic test_single_byte();
      a_word1 = 8'hA5;
      b_word1 = 8'hA5;
      start1  = 1'b1;
      tick();
      start1  = 1'b0;
      checks++;
      if ({cmp_en1, done1} !== 2'b10 || cmp_a1 !== 8'hA5 || cmp_b1 !== 8'hA5) begin
         errors++;
         $display("FAIL n1_c1 got en=%b done=%b a=%h b=%h exp 1 0 a5 a5", cmp_en1, done1, cmp_a1, cmp_b1);
      end
      tick();
      checks++;
      if ({done1, eq_flag1, cmp_en1} !== 3'b110) begin
         errors++;
         $display("FAIL n1_done c2 got done=%b eq=%b en=%b exp 1 1 0", done1, eq_flag1, cmp_en1);
      end
      tick();
      checks++;
      if ({done1, busy1} !== 2'b00) begin
         errors++;
         $display("FAIL n1_idle c3 got done=%b busy=%b exp 0 0", done1, busy1);
      end
      a_word1 = 8'hA5;
      b_word1 = 8'h5A;
      start1  = 1'b1;
      tick();
      start1  = 1'b0;
      tick();
      checks++;
      if ({done1, eq_flag1} !== 2'b10) begin
         errors++;
         $display("FAIL n1_mismatch c2 got done=%b eq=%b exp 1 0", done1, eq_flag1);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_equal();
      test_early_mismatch();
      test_last_byte();
      test_back_to_back();
      test_async_reset();
      test_single_byte();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule

// File: doc/alu_cmp_seq.md
ALU_CMP_SEQ -- requirements
Module: alu_cmp_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4: operand width in bytes, legal range 1..16.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset; one clock, reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: request a compare; accepted only in IDLE.
REQ-005 SHALL have port a_word, input, 8*NBYTES ([8*NBYTES:1]): operand A.
REQ-006 SHALL have port b_word, input, 8*NBYTES ([8*NBYTES:1]): operand B.
REQ-007 SHALL have port busy, output, 1: high whenever state is not IDLE.
REQ-008 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-009 SHALL have port eq_flag, output, 1: result, 1 = all bytes equal; held until the next accepted start.
REQ-010 SHALL have port cmp_a, output, 8 ([8:1]): byte driven to the 8-bit comparator A input.
REQ-011 SHALL have port cmp_b, output, 8 ([8:1]): byte driven to the 8-bit comparator B input.
REQ-012 SHALL have port cmp_en, output, 1: comparator tristate enable.
REQ-013 SHALL have port cmp_eq, input, 1: comparator equality flag; valid only while cmp_en=1.

Function
REQ-014 SHALL implement FSM states IDLE, CMP and DONE.
REQ-015 SHALL take IDLE->CMP on start=1: latch a_word and b_word, set byte index to NBYTES, clear eq_flag.
REQ-016 SHALL, in CMP, drive cmp_en=1, cmp_a=A byte[idx] and cmp_b=B byte[idx] (byte k = bits 8k:8k-7), and sample cmp_eq at the closing edge.
REQ-017 SHALL go CMP->DONE with eq_flag=0 when the sampled cmp_eq=0 (early termination).
REQ-018 SHALL, when sampled cmp_eq=1 and idx>1, decrement idx and stay in CMP; order is most-significant byte first.
REQ-019 SHALL go CMP->DONE with eq_flag=1 when sampled cmp_eq=1 and idx=1.
REQ-020 SHALL assert done=1 for exactly the one DONE cycle, then take DONE->IDLE unconditionally.
REQ-021 SHALL produce done k+1 cycles after the start edge, where k = bytes compared: equal operands give NBYTES+1, first mismatch at byte j gives NBYTES-j+2.
REQ-022 SHALL hold cmp_en=0 and cmp_a=cmp_b=0 outside CMP; cmp_eq SHALL never be sampled while cmp_en=0 (bus may be Z).
REQ-023 SHALL ignore start while busy=1, including start during DONE; latched operands SHALL be unaffected.
REQ-024 SHALL ignore a_word and b_word changes after acceptance.
REQ-025 SHALL hold eq_flag constant in IDLE and DONE until the next accepted start.

Reset
REQ-026 SHALL, on rst=1 (asynchronous), force state IDLE, idx=NBYTES, busy=0, done=0, eq_flag=0, cmp_en=0, cmp_a=0, cmp_b=0.
REQ-027 SHALL abandon any compare in progress on rst asserted mid-operation, with no done pulse; the first start after rst release SHALL be accepted normally.

Structure
REQ-028 SHALL place FSM state encodings (IDLE=2'd0, CMP=2'd1, DONE=2'd2) and the default NBYTES in the shared ALU package.
REQ-029 SHALL keep the comparator external (connected via cmp_* ports); one natural sub-module, alu_cmp_byte_mux, SHALL select byte[idx] of each latched operand.

Verification
REQ-030 SHALL cover: A=B=0x12345678, start cycle 0 -> cmp_en high cycles 1-4, done at cycle 5, eq_flag=1.
REQ-031 SHALL cover: A=0xFF345678, B=0x12345678 -> cmp_en high cycle 1 only (cmp_a=0xFF, cmp_b=0x12), done at cycle 2, eq_flag=0.
REQ-032 SHALL cover: A=0x12345600, B=0x12345601 -> done at cycle 5, eq_flag=0, cmp_a sequence 0x12,0x34,0x56,0x00.
REQ-033 SHALL cover: second start pulsed at cycles 2 and 5 of an equal compare -> both ignored, single done at cycle 5, busy low at cycle 6.
REQ-034 SHALL cover: rst asserted asynchronously mid-cycle 2 of an equal compare -> outputs reset immediately, no done, next start completes with eq_flag=1.
REQ-035 SHALL cover: NBYTES=1, A=B=0xA5 -> done at cycle 2, eq_flag=1.
